// File: rtl/cache_backing_memory.sv
// Block-granular backing store for the cache refill/writeback handshake.
// Accepts one block read or write at a time, models a fixed access latency and pulses ready_mem on completion.
module cache_backing_memory #(
    parameter int WORD_SIZE       = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int BLOCK_SIZE      = WORDS_PER_BLOCK * WORD_SIZE,
    parameter int MEM_BLOCKS      = 1024,
    parameter int ADDR_WIDTH      = $clog2(MEM_BLOCKS),
    parameter int READ_LATENCY    = 4,
    parameter int WRITE_LATENCY   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  read_en_mem,
    input  logic                  write_en_mem,
    input  logic [ADDR_WIDTH-1:0] block_addr,
    input  logic [BLOCK_SIZE-1:0] data_in_block,
    output logic [BLOCK_SIZE-1:0] data_out_block,
    output logic                  ready_mem,
    output logic                  busy
);

    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'((WRITE_LATENCY > 1) ? WRITE_LATENCY - 2 : 0);

    if (MEM_BLOCKS < 1 || (MEM_BLOCKS & (MEM_BLOCKS - 1)) != 0) begin : g_bad_mem_blocks
        $error("cache_backing_memory: MEM_BLOCKS must be a power of two");
    end
    if (READ_LATENCY < 1 || WRITE_LATENCY < 1) begin : g_bad_latency
        $error("cache_backing_memory: READ_LATENCY and WRITE_LATENCY must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [BLOCK_SIZE-1:0]   wdata_q, wdata_d;
    logic [BLOCK_SIZE-1:0]   rdata_q;
    logic                    rd_commit;
    logic                    wr_commit;

    logic [BLOCK_SIZE-1:0] mem_q [MEM_BLOCKS] = '{default: '0};

    // NOTE: every signal assigned here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_commit = 1'b0;
        wr_commit = 1'b0;
        case (state_q)
            IDLE: begin
                // A simultaneous read stays pending; the controller holds it until its own ready.
                if (write_en_mem) begin
                    addr_d  = block_addr;
                    wdata_d = data_in_block;
                    if (WRITE_LATENCY == 1) begin
                        state_d   = RESP;
                        wr_commit = 1'b1;
                    end else begin
                        state_d = WR_WAIT;
                        cnt_d   = WR_LOAD;
                    end
                end else if (read_en_mem) begin
                    addr_d = block_addr;
                    if (READ_LATENCY == 1) begin
                        state_d   = RESP;
                        rd_commit = 1'b1;
                    end else begin
                        state_d = RD_WAIT;
                        cnt_d   = RD_LOAD;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    state_d   = RESP;
                    rd_commit = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR_WAIT: begin
                if (cnt_q == '0) begin
                    state_d   = RESP;
                    wr_commit = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            if (rd_commit) begin
                rdata_q <= mem_q[addr_d];
            end
        end
    end

    // NOTE: the storage array is deliberately left out of reset; contents must survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            mem_q[addr_d] <= wdata_d;
        end
    end

    assign data_out_block = rdata_q;
    assign ready_mem      = (state_q == RESP);
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_cache_backing_memory.sv
// Directed bench for cache_backing_memory: a latency-4 instance and a latency-1 instance,
// each shadowed by a transaction-level model that is compared every cycle.
module tb_cache_backing_memory;

    localparam int BW = 128;
    localparam int AW = 10;
    localparam int LAT0 = 4;
    localparam int LAT1 = 1;

    localparam logic [BW-1:0] D_A = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [BW-1:0] D_B = 128'h10101010_20202020_30303030_40404040;
    localparam logic [BW-1:0] D_C = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    localparam logic [BW-1:0] D_D = 128'h3FF03FF0_12345678_9ABCDEF0_0BADF00D;
    localparam logic [BW-1:0] D_E = 128'hEEEEEEEE_11111111_22222222_33333333;
    localparam logic [BW-1:0] D_X = 128'h0000000X_FACEFACE_00000001_00000002 & 128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF | 128'h11110000_0_0_0;
    localparam logic [BW-1:0] D_Y = 128'hC0FFEE00_C0FFEE11_C0FFEE22_C0FFEE33;
    localparam logic [BW-1:0] D_Z = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;

    logic          clk;
    logic          rst_n;
    logic          rd_en [2];
    logic          wr_en [2];
    logic [AW-1:0] addr;
    logic [BW-1:0] data_in;
    logic [BW-1:0] dout  [2];
    logic          ready [2];
    logic          busy  [2];

    int  n_cmp  = 0;
    int  n_fail = 0;
    bit  running = 1'b0;
    int  pulses   [2] = '{0, 0};
    int  busy_cyc [2] = '{0, 0};

    cache_backing_memory #(
        .READ_LATENCY (LAT0),
        .WRITE_LATENCY(LAT0)
    ) dut0 (
        .clk           (clk),
        .rst_n         (rst_n),
        .read_en_mem   (rd_en[0]),
        .write_en_mem  (wr_en[0]),
        .block_addr    (addr),
        .data_in_block (data_in),
        .data_out_block(dout[0]),
        .ready_mem     (ready[0]),
        .busy          (busy[0])
    );

    cache_backing_memory #(
        .READ_LATENCY (LAT1),
        .WRITE_LATENCY(LAT1)
    ) dut1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .read_en_mem   (rd_en[1]),
        .write_en_mem  (wr_en[1]),
        .block_addr    (addr),
        .data_in_block (data_in),
        .data_out_block(dout[1]),
        .ready_mem     (ready[1]),
        .busy          (busy[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a request taken while idle lasts exactly L edges; the block
    // transfer and the ready cycle happen one edge before the transaction ends.
    logic [BW-1:0] m_mem  [int];
    bit            m_act  [2] = '{1'b0, 1'b0};
    int            m_left [2] = '{0, 0};
    bit            m_wr   [2];
    int            m_key  [2];
    logic [BW-1:0] m_data [2];
    logic [BW-1:0] m_dout [2] = '{'0, '0};

    function automatic int lat_of(input int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    m_act[i]  = 1'b0;
                    m_left[i] = 0;
                    m_dout[i] = '0;
                end else begin
                    if (m_act[i]) begin
                        m_left[i]--;
                        if (m_left[i] == 0) m_act[i] = 1'b0;
                    end else if (wr_en[i] || rd_en[i]) begin
                        m_act[i]  = 1'b1;
                        m_left[i] = lat_of(i);
                        m_wr[i]   = wr_en[i];
                        m_key[i]  = i * 2048 + int'(addr);
                        m_data[i] = data_in;
                    end
                    if (m_act[i] && m_left[i] == 1) begin
                        if (m_wr[i]) m_mem[m_key[i]] = m_data[i];
                        else m_dout[i] = m_mem.exists(m_key[i]) ? m_mem[m_key[i]] : '0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (running) begin
                for (int i = 0; i < 2; i++) begin
                    check($sformatf("ready%0d", i), BW'(ready[i]), BW'(m_act[i] && m_left[i] == 1));
                    check($sformatf("busy%0d", i), BW'(busy[i]), BW'(m_act[i]));
                    check($sformatf("dout%0d", i), dout[i], m_dout[i]);
                    if (ready[i] === 1'b1) pulses[i]++;
                    if (busy[i] === 1'b1) busy_cyc[i]++;
                end
            end
        end
    end

    // Counts cycles (1 = the cycle right after the acceptance edge) until ready is seen; -1 on timeout.
    task automatic wait_ready(input int inst, output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ready[inst] === 1'b1) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) $display("FAIL timeout: no ready_mem on instance %0d", inst);
    endtask

    task automatic xact(input int inst, input bit wr, input logic [AW-1:0] a,
                        input logic [BW-1:0] d, output int lat);
        addr    = a;
        data_in = d;
        wr_en[inst] = wr;
        rd_en[inst] = !wr;
        @(posedge clk); #1;
        wait_ready(inst, lat);
        @(posedge clk); #1;
        wr_en[inst] = 1'b0;
        rd_en[inst] = 1'b0;
    endtask

    initial begin
        int lat;
        int p0;
        int b1;
        rst_n   = 1'b1;
        rd_en[0] = 1'b0; rd_en[1] = 1'b0;
        wr_en[0] = 1'b0; wr_en[1] = 1'b0;
        addr    = '0;
        data_in = '0;
        running = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_dout", dout[0], '0);
        check("reset_busy", BW'(busy[0]), '0);
        check("reset_ready", BW'(ready[0]), '0);
        rst_n = 1'b1;

        // Write then read 0x05.
        xact(0, 1'b1, 10'h005, D_A, lat);
        check("wr05_latency", BW'(lat), BW'(4));
        xact(0, 1'b0, 10'h005, '0, lat);
        check("rd05_latency", BW'(lat), BW'(4));
        check("rd05_data", dout[0], D_A);

        // Simultaneous read and write of 0x10: write first, then the held read.
        p0 = pulses[0];
        addr = 10'h010; data_in = D_B; wr_en[0] = 1'b1; rd_en[0] = 1'b1;
        @(posedge clk); #1;
        wait_ready(0, lat);
        check("simul_wr_latency", BW'(lat), BW'(4));
        @(posedge clk); #1;
        wr_en[0] = 1'b0;
        @(posedge clk); #1;
        wait_ready(0, lat);
        check("simul_rd_latency", BW'(lat), BW'(4));
        @(posedge clk); #1;
        rd_en[0] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("simul_pulses", BW'(pulses[0] - p0), BW'(2));
        check("simul_data", dout[0], D_B);

        // Minimum latency instance.
        b1 = busy_cyc[1];
        xact(1, 1'b1, 10'h022, D_C, lat);
        check("minlat_wr_latency", BW'(lat), BW'(1));
        check("minlat_busy_cycles", BW'(busy_cyc[1] - b1), BW'(1));
        xact(1, 1'b0, 10'h022, '0, lat);
        check("minlat_rd_latency", BW'(lat), BW'(1));
        check("minlat_rd_data", dout[1], D_C);

        // Dropped read of 0x3FF; address changed mid-flight must be ignored.
        xact(0, 1'b1, 10'h3FF, D_D, lat);
        p0 = pulses[0];
        addr = 10'h3FF; rd_en[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rd_en[0] = 1'b0;
        addr = 10'h005;
        wait_ready(0, lat);
        check("drop_latency", BW'(lat + 1), BW'(4));
        check("drop_data", dout[0], D_D);
        repeat (10) @(posedge clk);
        #1;
        check("drop_pulses", BW'(pulses[0] - p0), BW'(1));

        // Reset mid-RD_WAIT clears outputs; array survives.
        addr = 10'h005; rd_en[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0; rd_en[0] = 1'b0;
        #1;
        check("rstmid_dout", dout[0], '0);
        check("rstmid_busy", BW'(busy[0]), '0);
        check("rstmid_ready", BW'(ready[0]), '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        // Reset mid-WR_WAIT discards the write to 0x07.
        addr = 10'h007; data_in = D_E; wr_en[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0; wr_en[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        xact(0, 1'b0, 10'h005, '0, lat);
        check("rst_array_kept", dout[0], D_A);
        xact(0, 1'b0, 10'h007, '0, lat);
        check("rst_wr_discard_lat", BW'(lat), BW'(4));
        check("rst_wr_discarded", dout[0], '0);

        // Writeback isolation on 0x01; data/addr changes after acceptance are ignored.
        xact(0, 1'b1, 10'h001, D_X, lat);
        xact(0, 1'b0, 10'h001, '0, lat);
        check("wb_first_read", dout[0], D_X);
        addr = 10'h001; data_in = D_Y; wr_en[0] = 1'b1;
        @(posedge clk); #1;
        data_in = D_Z; addr = 10'h002;
        wait_ready(0, lat);
        check("wb_write_latency", BW'(lat), BW'(4));
        @(posedge clk); #1;
        wr_en[0] = 1'b0;
        check("wb_dout_held", dout[0], D_X);
        xact(0, 1'b0, 10'h001, '0, lat);
        check("wb_second_read", dout[0], D_Y);
        xact(0, 1'b0, 10'h002, '0, lat);
        check("wb_no_stray_write", dout[0], '0);

        repeat (3) @(posedge clk);
        running = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
